renkon_linebuf: RTL and testbench
=================================

RENKON_LINEBUF -- requirements
Module: renkon_linebuf

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16, pixel word width in bits.
REQ-002 The block SHALL have parameter FSIZE, default 5, square filter window edge.
REQ-003 The block SHALL have parameter MAXW, default 32, maximum image width in pixels.
REQ-004 The block SHALL have parameter LWIDTH, default 6, width of the size and counter fields (clog2(MAXW+1)).
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset: clk (input, 1), the single rising-edge clock; xrst (input, 1), the asynchronous active-low reset.
REQ-006 The block SHALL have start, input, 1 bit: frame start pulse that latches img_width and img_height.
REQ-007 The block SHALL have img_width, input, LWIDTH bits: frame width in pixels.
REQ-008 The block SHALL have img_height, input, LWIDTH bits: frame height in pixels.
REQ-009 The block SHALL have in_valid, input, 1 bit: qualifies in_data, one pixel per beat, raster order.
REQ-010 The block SHALL have in_data, input, DWIDTH bits: pixel value.
REQ-011 The block SHALL have busy, output, 1 bit: high while a frame is in progress.
REQ-012 The block SHALL have out_valid, output, 1 bit: qualifies out_data for exactly one cycle per window.
REQ-013 The block SHALL have out_data, output, FSIZE*FSIZE*DWIDTH bits: flattened window.
REQ-014 The block SHALL have done, output, 1 bit: one-cycle pulse after the last pixel of the frame.
REQ-015 The block SHALL have err, output, 1 bit: one-cycle pulse on a rejected start.

Function
REQ-016 The FSM SHALL have states S_IDLE, S_RUN and S_DONE.
REQ-017 In S_IDLE, start with FSIZE <= img_width <= MAXW and img_height >= FSIZE SHALL latch both sizes, clear the column and row counters, and go to S_RUN.
REQ-018 A start with out-of-range sizes SHALL pulse err on the next cycle and leave the FSM in S_IDLE.
REQ-019 In S_RUN, each in_valid beat SHALL advance col; at col == width-1, col SHALL wrap to 0 and row SHALL increment.
REQ-020 Cycles with in_valid low SHALL hold all state unchanged, with no output.
REQ-021 Each in_valid beat SHALL push in_data through FSIZE-1 chained line delays of length width, so that line k outputs the pixel from k rows above.
REQ-022 The window register SHALL shift left one column per beat, loading a new column {line FSIZE-1 .. line 1, in_data}.
REQ-023 out_valid SHALL be asserted one cycle after a beat at which row >= FSIZE-1 and col >= FSIZE-1, i.e. with latency 1.
REQ-024 out_data element i*FSIZE+j (element 0 at the LSBs) SHALL be pixel (row-FSIZE+1+i, col-FSIZE+1+j) of that beat.
REQ-025 The beat with row == height-1 and col == width-1 SHALL move the FSM to S_DONE.
REQ-026 S_DONE SHALL last one cycle, asserting done (coincident with the last out_valid), then return to S_IDLE.
REQ-027 start while busy SHALL be ignored, with no err.
REQ-028 in_valid in S_IDLE or S_DONE SHALL be ignored.
REQ-029 busy SHALL be 1 exactly in S_RUN.
REQ-030 Line memories SHALL need no clearing between frames, because the row gating masks stale data.

Reset
REQ-031 When xrst is low, FSM = S_IDLE and busy, out_valid, done and err = 0, asynchronously.
REQ-032 When xrst is low, counters, latched sizes and out_data SHALL be 0.
REQ-033 Reset mid-frame SHALL abort the frame; the next start SHALL behave as after power-up.
REQ-034 Line memory contents SHALL NOT be reset.

Structure
REQ-035 DWIDTH, FSIZE, MAXW, LWIDTH and the state enum SHALL live in the shared package renkon_pkg.
REQ-036 One line delay SHALL be sub-module renkon_linebuf_row: a circular RAM of depth MAXW, tap at runtime length width, instantiated FSIZE-1 times.

Verification
REQ-037 Width 8, height 6, ramp pixel = row*8+col, continuous in_valid SHALL produce the first out_valid one cycle after pixel 36, with element 0 = 0, element 4 = 4, element 20 = 32 and element 24 = 36.
REQ-038 The same frame SHALL produce exactly 8 out_valid pulses, the last with element 24 = 47, done coincident with it, and busy falling the next cycle.
REQ-039 The same frame with in_valid toggling 1/0 SHALL produce identical window contents and count, each out_valid one cycle after its completing beat.
REQ-040 start with img_width = 4, or img_width = 33, SHALL pulse err once and keep busy = 0; subsequent in_valid beats SHALL produce no out_valid.
REQ-041 xrst pulsed low after 20 pixels, then a new 8x6 frame, SHALL give all outputs 0 during reset and a second frame result identical to REQ-037 and REQ-038.
REQ-042 Back-to-back frames (start the cycle after done), the second with ramp + 100, SHALL produce a first window with element 0 = 100, with no stale data.

Source files
------------

// File: rtl/renkon_pkg.sv
// rtl/renkon_pkg.sv - shared sizes and FSM state type for the renkon line buffer
package renkon_pkg;

    localparam int DWIDTH = 16;
    localparam int FSIZE  = 5;
    localparam int MAXW   = 32;
    localparam int LWIDTH = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/renkon_linebuf_row.sv
// rtl/renkon_linebuf_row.sv - one line delay: circular RAM tapped at the runtime image width
module renkon_linebuf_row #(
    parameter int DWIDTH = 16,
    parameter int MAXW   = 32,
    parameter int LWIDTH = 6
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              clear,
    input  logic              en,
    input  logic [LWIDTH-1:0] width,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout
);

    localparam int AW = (MAXW > 1) ? $clog2(MAXW) : 1;

    // Contents are never reset: rows not yet written are masked by the row gating upstream.
    logic [DWIDTH-1:0] mem [MAXW];
    logic [LWIDTH-1:0] ptr;

    // The slot about to be overwritten holds the pixel written exactly width beats ago.
    assign dout = mem[ptr[AW-1:0]];

    // Pointer walks 0..width-1 and restarts at every accepted frame start.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (en) begin
            if (ptr == width - 1'b1) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // Write the incoming pixel into the slot just read out.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/renkon_linebuf.sv
// rtl/renkon_linebuf.sv - raster line buffer producing FSIZE x FSIZE pixel windows
module renkon_linebuf
    import renkon_pkg::*;
#(
    parameter int DWIDTH = renkon_pkg::DWIDTH,
    parameter int FSIZE  = renkon_pkg::FSIZE,
    parameter int MAXW   = renkon_pkg::MAXW,
    parameter int LWIDTH = renkon_pkg::LWIDTH
) (
    input  logic                            clk,
    input  logic                            xrst,
    input  logic                            start,
    input  logic [LWIDTH-1:0]               img_width,
    input  logic [LWIDTH-1:0]               img_height,
    input  logic                            in_valid,
    input  logic [DWIDTH-1:0]               in_data,
    output logic                            busy,
    output logic                            out_valid,
    output logic [FSIZE*FSIZE*DWIDTH-1:0]   out_data,
    output logic                            done,
    output logic                            err
);

    state_t            state;
    logic [LWIDTH-1:0] width_q;
    logic [LWIDTH-1:0] height_q;
    logic [LWIDTH-1:0] col;
    logic [LWIDTH-1:0] row;
    logic [FSIZE*FSIZE*DWIDTH-1:0] win;

    logic size_ok;
    logic accept;
    logic beat;

    // line[0] is the live pixel, line[k] the pixel k rows above it.
    logic [DWIDTH-1:0] line [FSIZE];

    assign size_ok = (img_width >= LWIDTH'(FSIZE)) && (img_width <= LWIDTH'(MAXW)) &&
                     (img_height >= LWIDTH'(FSIZE));
    assign accept  = (state == S_IDLE) && start && size_ok;
    assign beat    = (state == S_RUN) && in_valid;
    assign line[0] = in_data;
    assign out_data = win;

    genvar k;
    generate
        for (k = 1; k < FSIZE; k++) begin : g_row
            renkon_linebuf_row #(
                .DWIDTH (DWIDTH),
                .MAXW   (MAXW),
                .LWIDTH (LWIDTH)
            ) u_row (
                .clk   (clk),
                .xrst  (xrst),
                .clear (accept),
                .en    (beat),
                .width (width_q),
                .din   (line[k-1]),
                .dout  (line[k])
            );
        end
    endgenerate

    // Frame control: size latch, raster counters and the registered status pulses.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state     <= S_IDLE;
            width_q   <= '0;
            height_q  <= '0;
            col       <= '0;
            row       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (size_ok) begin
                            width_q  <= img_width;
                            height_q <= img_height;
                            col      <= '0;
                            row      <= '0;
                            busy     <= 1'b1;
                            state    <= S_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        out_valid <= (row >= LWIDTH'(FSIZE - 1)) && (col >= LWIDTH'(FSIZE - 1));
                        if (col == width_q - 1'b1) begin
                            col <= '0;
                            if (row == height_q - 1'b1) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Window slides one column left per beat; the new right column is oldest row at i=0.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            win <= '0;
        end else if (beat) begin
            for (int i = 0; i < FSIZE; i++) begin
                for (int j = 0; j < FSIZE - 1; j++) begin
                    win[(i*FSIZE+j)*DWIDTH +: DWIDTH] <= win[(i*FSIZE+j+1)*DWIDTH +: DWIDTH];
                end
                win[(i*FSIZE+FSIZE-1)*DWIDTH +: DWIDTH] <= line[FSIZE-1-i];
            end
        end
    end

endmodule

// File: tb/tb_renkon_linebuf.sv
// tb/tb_renkon_linebuf.sv - scoreboard bench for renkon_linebuf
module tb_renkon_linebuf;

    localparam int DW = 16;
    localparam int FS = 5;
    localparam int OW = FS*FS*DW;

    logic          clk = 1'b0;
    logic          xrst = 1'b1;
    logic          start = 1'b0;
    logic [5:0]    img_width = '0;
    logic [5:0]    img_height = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          busy;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          done;
    logic          err;

    typedef struct {
        logic [OW-1:0] data;
        int            tag;
        bit            last;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ov_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int frame [64][64];

    renkon_linebuf dut (
        .clk        (clk),
        .xrst       (xrst),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: pop the scoreboard whenever a window is presented.
    always @(negedge clk) begin
        exp_t e;
        if (xrst === 1'b1) begin
            if (err) err_cnt++;
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", busy, 0);
                if (!out_valid) chk("valid_with_done", out_valid, 1);
            end
            if (out_valid) begin
                ov_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("window", out_data, e.data);
                    chk("latency", cyc, e.tag);
                    chk("done_at_last", done, e.last);
                end
            end
        end
    end

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        chk("done_seen", got, 1);
        @(posedge clk); #1;
        chk("sb_empty", sb.size(), 0);
        chk("busy_after_done", busy, 0);
    endtask

    // Caller is always 1 time unit after a rising edge on entry and exit.
    task automatic run_frame(input int w, input int h, input int base, input int rnd,
                             input int gap, input int inj, input int abort_at);
        int n = 0;
        logic [OW-1:0] ev;
        start = 1; img_width = 6'(w); img_height = 6'(h);
        @(posedge clk); #1;
        start = 0;
        chk("busy_after_start", busy, 1);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (n == abort_at) begin
                    xrst = 0; in_valid = 0;
                    #1;
                    chk("rst_busy", busy, 0);
                    chk("rst_out_valid", out_valid, 0);
                    chk("rst_done", done, 0);
                    chk("rst_err", err, 0);
                    chk("rst_out_data", out_data, 0);
                    @(posedge clk); @(posedge clk); #1;
                    xrst = 1;
                    sb.delete();
                    return;
                end
                if (n > 0) begin
                    int idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
                    for (int g = 0; g < idle; g++) begin
                        in_valid = 0;
                        in_data = DW'($urandom);
                        @(posedge clk); #1;
                    end
                end
                frame[r][c] = (rnd != 0) ? int'($urandom_range(0, 65535)) : base + r*w + c;
                in_valid = 1;
                in_data = DW'(frame[r][c]);
                if (inj != 0 && n == 10) begin
                    start = 1; img_width = 6'd5; img_height = 6'd5;
                end
                if (r >= FS-1 && c >= FS-1) begin
                    exp_t e;
                    for (int i = 0; i < FS; i++)
                        for (int j = 0; j < FS; j++)
                            ev[(i*FS+j)*DW +: DW] = DW'(frame[r-FS+1+i][c-FS+1+j]);
                    e.data = ev;
                    e.tag = cyc + 1;
                    e.last = (r == h-1) && (c == w-1);
                    sb.push_back(e);
                end
                @(posedge clk); #1;
                in_valid = 0;
                start = 0;
                n++;
            end
        end
        wait_done();
    endtask

    task automatic bad_start(input int w, input int h);
        int e0 = err_cnt;
        start = 1; img_width = 6'(w); img_height = 6'(h);
        @(posedge clk); #1;
        start = 0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(posedge clk); #1;
        chk("err_one_cycle", err, 0);
        for (int i = 0; i < 40; i++) begin
            in_valid = 1;
            in_data = DW'(i);
            @(posedge clk); #1;
        end
        in_valid = 0;
        @(posedge clk); #1;
        chk("err_count", err_cnt - e0, 1);
        chk("err_busy_after", busy, 0);
    endtask

    task automatic good_frame(input int w, input int h, input int base, input int rnd,
                              input int gap, input int inj);
        int ov0 = ov_cnt;
        int dn0 = done_cnt;
        int er0 = err_cnt;
        run_frame(w, h, base, rnd, gap, inj, -1);
        chk("window_count", ov_cnt - ov0, (w-FS+1)*(h-FS+1));
        chk("done_count", done_cnt - dn0, 1);
        chk("no_err", err_cnt - er0, 0);
    endtask

    initial begin
        xrst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_out_data", out_data, 0);
        xrst = 1;
        @(posedge clk); #1;

        good_frame(8, 6, 0, 0, 0, 0);
        good_frame(8, 6, 100, 0, 0, 1);
        good_frame(8, 6, 0, 0, 1, 0);

        bad_start(4, 6);
        bad_start(33, 6);
        bad_start(8, 4);

        run_frame(8, 6, 0, 0, 0, 0, 20);
        @(posedge clk); #1;
        good_frame(8, 6, 0, 0, 0, 0);

        good_frame(5, 5, 0, 1, 2, 0);
        good_frame(32, 7, 0, 1, 2, 0);
        good_frame(13, 9, 0, 1, 2, 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
